// File: rtl/alu_operand_sel_stage.sv
// alu_operand_sel_stage
//  One-entry valid/ready stage that turns the one-hot instruction-class code from
//  decode into the ALU operand-A / operand-B selects. It flags codes that are not
//  exactly one-hot and keeps a sticky error flag plus a saturating error counter.
//  Class bits: 0 J, 1 JALR, 2 LUI, 3 AUIPC, 4 B, 5 R, 6 S, 7 I-ALU, 8 LOAD, 9 CSR.
//  Bits 10 and up are reserved, and any reserved bit set makes the code illegal.
//  Optional feature macro ALU_OPSEL_FORWARD_EN: when it is defined, fwd_a picks the
//  EX or MEM result for rs1. When it is undefined, fwd_a is held at 2'b00.
module alu_operand_sel_stage #(
    parameter int CODE_W     = 10,
    parameter int REG_ADDR_W = 5,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_W-1:0]     code,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wr,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_wr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            alu_sel_a,
    output logic                  alu_sel_b,
    output logic [1:0]            fwd_a,
    output logic                  illegal,
    output logic                  err_flag,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    input  logic                  err_clr
);

    localparam int CLS_W = 10;

    // A code is legal only if exactly one bit is set and that bit is a defined class.
    function automatic logic code_legal(input logic [CODE_W-1:0] c);
        logic [CODE_W-1:0] dec_m;
        dec_m      = c - {{(CODE_W-1){1'b0}}, 1'b1};
        code_legal = (c != {CODE_W{1'b0}}) &&
                     ((c & dec_m) == {CODE_W{1'b0}}) &&
                     ((c >> CLS_W) == {CODE_W{1'b0}});
    endfunction

    logic                 acc_s;
    logic                 legal_s;
    logic [1:0]           dec_a_s;
    logic                 dec_b_s;
    logic [1:0]           fwd_s;
    logic                 cnt_sat_s;

    logic                 out_valid_r;
    logic [1:0]           sel_a_r;
    logic                 sel_b_r;
    logic [1:0]           fwd_r;
    logic                 illegal_r;
    logic                 err_flag_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    assign in_ready  = ~out_valid_r | out_ready;
    assign acc_s     = in_valid & in_ready;
    assign legal_s   = code_legal(code);
    assign cnt_sat_s = (err_cnt_r == {ERR_CNT_W{1'b1}});

    // Map the instruction class onto the operand selects. Illegal codes fall back to rs1/rs2.
    always_comb begin
        dec_a_s = 2'b00;
        dec_b_s = 1'b0;
        if (legal_s) begin
            case (code[CLS_W-1:0])
                10'h001: begin dec_a_s = 2'b01; dec_b_s = 1'b1; end  // J
                10'h002: begin dec_a_s = 2'b00; dec_b_s = 1'b1; end  // JALR
                10'h004: begin dec_a_s = 2'b10; dec_b_s = 1'b1; end  // LUI
                10'h008: begin dec_a_s = 2'b01; dec_b_s = 1'b1; end  // AUIPC
                10'h010: begin dec_a_s = 2'b00; dec_b_s = 1'b0; end  // B
                10'h020: begin dec_a_s = 2'b00; dec_b_s = 1'b0; end  // R
                10'h040: begin dec_a_s = 2'b00; dec_b_s = 1'b1; end  // S
                10'h080: begin dec_a_s = 2'b00; dec_b_s = 1'b1; end  // I-ALU
                10'h100: begin dec_a_s = 2'b00; dec_b_s = 1'b1; end  // LOAD
                10'h200: begin dec_a_s = 2'b00; dec_b_s = 1'b1; end  // CSR
                default: begin dec_a_s = 2'b00; dec_b_s = 1'b0; end
            endcase
        end else begin
            dec_a_s = 2'b00;
            dec_b_s = 1'b0;
        end
    end

`ifdef ALU_OPSEL_FORWARD_EN
    // Choose the rs1 forwarding source. EX is newer than MEM, so EX wins. x0 is never forwarded.
    always_comb begin
        fwd_s = 2'b00;
        if (!legal_s || (dec_a_s != 2'b00)) begin
            fwd_s = 2'b00;
        end else if (ex_wr && (ex_rd != {REG_ADDR_W{1'b0}}) && (ex_rd == rs1_addr)) begin
            fwd_s = 2'b01;
        end else if (mem_wr && (mem_rd != {REG_ADDR_W{1'b0}}) && (mem_rd == rs1_addr)) begin
            fwd_s = 2'b10;
        end else begin
            fwd_s = 2'b00;
        end
    end
`else
    logic unused_fwd_inputs_s;
    assign unused_fwd_inputs_s = ^{rs1_addr, ex_rd, ex_wr, mem_rd, mem_wr};

    // Forwarding is not built, so operand A always comes from the register file.
    always_comb begin
        fwd_s = 2'b00;
    end
`endif

    // Pipeline register. Load on accept, drop valid once consumed, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sel_a_r     <= 2'b00;
            sel_b_r     <= 1'b0;
            fwd_r       <= 2'b00;
            illegal_r   <= 1'b0;
        end else if (acc_s) begin
            out_valid_r <= 1'b1;
            sel_a_r     <= dec_a_s;
            sel_b_r     <= dec_b_s;
            fwd_r       <= fwd_s;
            illegal_r   <= ~legal_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Error bookkeeping. A clear in the same cycle as an illegal accept is applied first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_r <= 1'b0;
            err_cnt_r  <= {ERR_CNT_W{1'b0}};
        end else if (acc_s && !legal_s) begin
            err_flag_r <= 1'b1;
            if (err_clr) begin
                err_cnt_r <= {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else if (!cnt_sat_s) begin
                err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else if (err_clr) begin
            err_flag_r <= 1'b0;
            err_cnt_r  <= {ERR_CNT_W{1'b0}};
        end else begin
            err_flag_r <= err_flag_r;
            err_cnt_r  <= err_cnt_r;
        end
    end

    assign out_valid = out_valid_r;
    assign alu_sel_a = sel_a_r;
    assign alu_sel_b = sel_b_r;
    assign fwd_a     = fwd_r;
    assign illegal   = illegal_r;
    assign err_flag  = err_flag_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_alu_operand_sel_stage.sv
// Bench for alu_operand_sel_stage.
// Instance A uses the defaults. Instance B uses a 12-bit code (two reserved bits)
// and a 2-bit error counter.
// A behavioural model, built from the class table and plain integer arithmetic,
// is compared against both instances on every falling clock edge.
module tb_alu_operand_sel_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [11:0] code = 12'h000;
    logic [4:0]  rs1_addr = 5'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic [4:0]  mem_rd = 5'd0;
    logic        ex_wr = 1'b0;
    logic        mem_wr = 1'b0;

    logic       rdy_a, vld_a, selb_a, ill_a, flg_a;
    logic [1:0] sela_a, fwd_a_a;
    logic [7:0] cnt_a;
    logic       rdy_b, vld_b, selb_b, ill_b, flg_b;
    logic [1:0] sela_b, fwd_a_b;
    logic [1:0] cnt_b;

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    alu_operand_sel_stage dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .code(code[9:0]), .rs1_addr(rs1_addr), .ex_rd(ex_rd), .ex_wr(ex_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .out_valid(vld_a), .out_ready(out_ready),
        .alu_sel_a(sela_a), .alu_sel_b(selb_a), .fwd_a(fwd_a_a), .illegal(ill_a),
        .err_flag(flg_a), .err_cnt(cnt_a), .err_clr(err_clr)
    );

    alu_operand_sel_stage #(.CODE_W(12), .REG_ADDR_W(5), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .code(code), .rs1_addr(rs1_addr), .ex_rd(ex_rd), .ex_wr(ex_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .out_valid(vld_b), .out_ready(out_ready),
        .alu_sel_a(sela_b), .alu_sel_b(selb_b), .fwd_a(fwd_a_b), .illegal(ill_b),
        .err_flag(flg_b), .err_cnt(cnt_b), .err_clr(err_clr)
    );

    // ---------------- behavioural model ----------------
    function automatic logic [11:0] view(input int i, input logic [11:0] c);
        return (i == 0) ? {2'b00, c[9:0]} : c;
    endfunction

    function automatic int cls_idx(input logic [11:0] c);   // -1 when illegal
        int idx = -1;
        if ($countones(c) != 1) return -1;
        for (int k = 0; k < 12; k++) if (c[k]) idx = k;
        return (idx >= 10) ? -1 : idx;
    endfunction

    function automatic logic [1:0] m_sela(input logic [11:0] c);
        int k = cls_idx(c);
        if (k == 0 || k == 3) return 2'b01;
        if (k == 2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_selb(input logic [11:0] c);
        int k = cls_idx(c);
        return !(k < 0 || k == 4 || k == 5);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [11:0] c);
`ifdef ALU_OPSEL_FORWARD_EN
        if (cls_idx(c) < 0 || m_sela(c) != 2'b00) return 2'b00;
        if (ex_wr && ex_rd != 5'd0 && ex_rd == rs1_addr) return 2'b01;
        if (mem_wr && mem_rd != 5'd0 && mem_rd == rs1_addr) return 2'b10;
        return 2'b00;
`else
        return (c == 12'hfff) ? 2'b00 : 2'b00;
`endif
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    logic       m_valid;
    logic [1:0] m_a [2];
    logic       m_b [2];
    logic [1:0] m_f [2];
    logic       m_ill [2];
    logic       m_flag [2];
    int         m_cnt [2];

    // Reference model of both instances.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_a[i] <= 2'b00; m_b[i] <= 1'b0; m_f[i] <= 2'b00;
                m_ill[i] <= 1'b0; m_flag[i] <= 1'b0; m_cnt[i] <= 0;
            end
        end else begin
            if (in_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                for (int i = 0; i < 2; i++) begin
                    m_a[i]   <= m_sela(view(i, code));
                    m_b[i]   <= m_selb(view(i, code));
                    m_f[i]   <= m_fwd(view(i, code));
                    m_ill[i] <= (cls_idx(view(i, code)) < 0);
                end
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (in_valid && (!m_valid || out_ready) && cls_idx(view(i, code)) < 0) begin
                    m_flag[i] <= 1'b1;
                    m_cnt[i]  <= err_clr ? 1 : ((m_cnt[i] + 1 > cnt_max(i)) ? cnt_max(i) : m_cnt[i] + 1);
                end else if (err_clr) begin
                    m_flag[i] <= 1'b0;
                    m_cnt[i]  <= 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rdy_a", {31'd0, rdy_a}, {31'd0, (!m_valid || out_ready)});
            chk("rdy_b", {31'd0, rdy_b}, {31'd0, (!m_valid || out_ready)});
            chk("vld_a", {31'd0, vld_a}, {31'd0, m_valid});
            chk("vld_b", {31'd0, vld_b}, {31'd0, m_valid});
            chk("sela_a", {30'd0, sela_a}, {30'd0, m_a[0]});
            chk("sela_b", {30'd0, sela_b}, {30'd0, m_a[1]});
            chk("selb_a", {31'd0, selb_a}, {31'd0, m_b[0]});
            chk("selb_b", {31'd0, selb_b}, {31'd0, m_b[1]});
            chk("fwd_a", {30'd0, fwd_a_a}, {30'd0, m_f[0]});
            chk("fwd_b", {30'd0, fwd_a_b}, {30'd0, m_f[1]});
            chk("ill_a", {31'd0, ill_a}, {31'd0, m_ill[0]});
            chk("ill_b", {31'd0, ill_b}, {31'd0, m_ill[1]});
            chk("flg_a", {31'd0, flg_a}, {31'd0, m_flag[0]});
            chk("flg_b", {31'd0, flg_b}, {31'd0, m_flag[1]});
            chk("cnt_a", {24'd0, cnt_a}, m_cnt[0]);
            chk("cnt_b", {30'd0, cnt_b}, m_cnt[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Directed literal expectations followed by randomized traffic.
    initial begin
        cyc(); cyc();
        chk("rst_vld", {31'd0, vld_a}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_a}, 32'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;

        code = 12'h008; cyc();
        chk("auipc_vld", {31'd0, vld_a}, 32'd1);
        chk("auipc_a", {30'd0, sela_a}, 32'd1);
        chk("auipc_b", {31'd0, selb_a}, 32'd1);
        chk("auipc_ill", {31'd0, ill_a}, 32'd0);
        code = 12'h004; cyc();
        chk("lui_a", {30'd0, sela_a}, 32'd2);
        chk("lui_b", {31'd0, selb_a}, 32'd1);
        code = 12'h020; cyc();
        chk("r_a", {30'd0, sela_a}, 32'd0);
        chk("r_b", {31'd0, selb_a}, 32'd0);
        code = 12'h200; cyc();
        chk("csr_a", {30'd0, sela_a}, 32'd0);
        chk("csr_b", {31'd0, selb_a}, 32'd1);

        // Stall: the J offer must not be taken while the CSR result is still held.
        out_ready = 1'b0; code = 12'h001; cyc(); cyc();
        chk("stall_rdy", {31'd0, rdy_a}, 32'd0);
        chk("stall_b", {31'd0, selb_a}, 32'd1);
        chk("stall_vld", {31'd0, vld_a}, 32'd1);
        out_ready = 1'b1; cyc();
        chk("unstall_a", {30'd0, sela_a}, 32'd1);

        // Illegal codes and the error clear.
        code = 12'h000; cyc();
        code = 12'h011; cyc();
        chk("ill2_ill", {31'd0, ill_a}, 32'd1);
        chk("ill2_a", {30'd0, sela_a}, 32'd0);
        chk("ill2_b", {31'd0, selb_a}, 32'd0);
        chk("ill2_cnt", {24'd0, cnt_a}, 32'd2);
        chk("ill2_flg", {31'd0, flg_a}, 32'd1);
        in_valid = 1'b0; err_clr = 1'b1; cyc();
        chk("clr_cnt", {24'd0, cnt_a}, 32'd0);
        chk("clr_flg", {31'd0, flg_a}, 32'd0);
        err_clr = 1'b0; in_valid = 1'b1; code = 12'h000;
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_cnt_a", {24'd0, cnt_a}, 32'd5);
        chk("sat_cnt_b", {30'd0, cnt_b}, 32'd3);
        err_clr = 1'b1; cyc();
        chk("clrev_cnt_a", {24'd0, cnt_a}, 32'd1);
        chk("clrev_cnt_b", {30'd0, cnt_b}, 32'd1);
        chk("clrev_flg_b", {31'd0, flg_b}, 32'd1);
        err_clr = 1'b0;

        // A reserved bit is illegal only for the 12-bit instance.
        code = 12'h401; cyc();
        chk("rsv_ill_a", {31'd0, ill_a}, 32'd0);
        chk("rsv_ill_b", {31'd0, ill_b}, 32'd1);

        // Forwarding scenario with EX and MEM both matching rs1.
        code = 12'h020; rs1_addr = 5'd5; ex_rd = 5'd5; ex_wr = 1'b1; mem_rd = 5'd5; mem_wr = 1'b1; cyc();
`ifdef ALU_OPSEL_FORWARD_EN
        chk("fwd_ex", {30'd0, fwd_a_a}, 32'd1);
        ex_wr = 1'b0; cyc();
        chk("fwd_mem", {30'd0, fwd_a_a}, 32'd2);
        rs1_addr = 5'd0; cyc();
        chk("fwd_x0", {30'd0, fwd_a_a}, 32'd0);
`else
        chk("fwd_off", {30'd0, fwd_a_a}, 32'd0);
`endif

        // Randomized traffic, with an occasional asynchronous reset pulse.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0) code = 12'h001 << $urandom_range(0, 11);
            else code = 12'($urandom);
            rs1_addr = 5'($urandom_range(0, 3));
            ex_rd    = 5'($urandom_range(0, 3));
            mem_rd   = 5'($urandom_range(0, 3));
            ex_wr    = 1'($urandom);
            mem_wr   = 1'($urandom);
            cyc();
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
